// File: rtl/trade_ouch_tx_pkg.sv
// Shared types and constants for the OUCH order-entry transmit path.
// The beat formatters map the 20-byte big-endian message onto three 64-bit AXI-Stream beats.
package trade_ouch_tx_pkg;

  localparam logic [1:0] ACTION_HOLD = 2'b00;
  localparam logic [1:0] ACTION_BUY  = 2'b01;
  localparam logic [1:0] ACTION_SELL = 2'b10;

  localparam logic [7:0] OUCH_TYPE_ENTER = 8'h4F;
  localparam logic [7:0] SIDE_BUY        = 8'h42;
  localparam logic [7:0] SIDE_SELL       = 8'h53;

  localparam int OUCH_MSG_BYTES = 20;

  typedef struct packed {
    logic        valid;
    logic [1:0]  action;
    logic [15:0] confidence;
    logic [31:0] price;
    logic [31:0] quantity;
  } trade_signal_t;

  typedef struct packed {
    logic [7:0]  side;
    logic [31:0] quantity;
    logic [31:0] price;
    logic [15:0] confidence;
    logic [31:0] timestamp;
  } ouch_entry_t;

  typedef enum logic [1:0] {ST_IDLE, ST_BEAT0, ST_BEAT1, ST_BEAT2} tx_state_t;

  function automatic logic [31:0] bswap32(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  function automatic logic [15:0] bswap16(input logic [15:0] v);
    return {v[7:0], v[15:8]};
  endfunction

  // Byte lane 0 is the first byte on the wire, so big-endian fields land byte-swapped.
  function automatic logic [63:0] ouch_beat0(input logic [7:0] side, input logic [31:0] token,
                                             input logic [31:0] quantity);
    return {quantity[23:16], quantity[31:24], bswap32(token), side, OUCH_TYPE_ENTER};
  endfunction

  function automatic logic [63:0] ouch_beat1(input logic [15:0] quantity_lo, input logic [31:0] price,
                                             input logic [15:0] confidence);
    return {bswap16(confidence), bswap32(price), quantity_lo[7:0], quantity_lo[15:8]};
  endfunction

  function automatic logic [63:0] ouch_beat2(input logic [31:0] timestamp);
    return {32'h0000_0000, bswap32(timestamp)};
  endfunction

endpackage

// File: rtl/trade_ouch_tx_sync_fifo.sv
// Synchronous FIFO with registered storage and a combinational head read.
// A push while full is accepted only if the same cycle pops.
module trade_ouch_tx_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   LVL_FULL = DEPTH[AW:0];
  localparam logic [AW:0]   LVL_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic             pop_ok_s;
  logic             push_ok_s;

  // Status flags and qualified push/pop strobes.
  always_comb begin
    full      = (level == LVL_FULL);
    empty     = (level == {(AW+1){1'b0}});
    pop_ok_s  = pop && !empty;
    push_ok_s = push && (!full || pop_ok_s);
    pop_data  = mem_r[rd_ptr_r];
  end

  // Storage write; the slot under rd_ptr is read before the edge that may overwrite it.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level    <= {(AW+1){1'b0}};
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      case ({push_ok_s, pop_ok_s})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/trade_ouch_tx.sv
// Filters trade signals, queues them with a timestamp and serialises each one
// as a 20-byte OUCH enter-order message over three 64-bit AXI-Stream beats.
module trade_ouch_tx
  import trade_ouch_tx_pkg::*;
#(
  parameter int          FIFO_DEPTH     = 16,
  parameter logic [15:0] MIN_CONFIDENCE = 16'h0000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  trade_signal_t               trade_in,
  output logic [63:0]                 m_axis_tdata,
  output logic [7:0]                  m_axis_tkeep,
  output logic                        m_axis_tvalid,
  output logic                        m_axis_tlast,
  input  logic                        m_axis_tready,
  output logic [31:0]                 tx_count,
  output logic [31:0]                 drop_count,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  tx_state_t   state_r;
  ouch_entry_t push_entry_s;
  ouch_entry_t head_s;
  logic [31:0] token_r;
  logic [31:0] ts_r;
  logic [15:0] qty_lo_r;
  logic [31:0] price_r;
  logic [15:0] conf_r;
  logic [31:0] stamp_r;
  logic [16:0] conf_diff_s;
  logic        conf_ok_s;
  logic        side_ok_s;
  logic        push_s;
  logic        pop_s;
  logic        handshake_s;
  logic        full_s;
  logic        empty_s;

  // Push qualification, entry packing and pop decision.
  always_comb begin
    // Bit 16 of (0x10000 + conf - min) is set exactly when conf >= min.
    conf_diff_s  = {1'b1, trade_in.confidence} - {1'b0, MIN_CONFIDENCE};
    conf_ok_s    = conf_diff_s[16];
    side_ok_s    = (trade_in.action == ACTION_BUY) || (trade_in.action == ACTION_SELL);
    push_s       = trade_in.valid && side_ok_s && conf_ok_s;
    push_entry_s.side       = (trade_in.action == ACTION_SELL) ? SIDE_SELL : SIDE_BUY;
    push_entry_s.quantity   = trade_in.quantity;
    push_entry_s.price      = trade_in.price;
    push_entry_s.confidence = trade_in.confidence;
    push_entry_s.timestamp  = ts_r;
    handshake_s  = m_axis_tvalid && m_axis_tready;
    if (state_r == ST_IDLE) begin
      pop_s = !empty_s;
    end else if (state_r == ST_BEAT2) begin
      pop_s = handshake_s && !empty_s;
    end else begin
      pop_s = 1'b0;
    end
  end

  trade_ouch_tx_sync_fifo #(
    .WIDTH($bits(ouch_entry_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_s),
    .push_data (push_entry_s),
    .pop       (pop_s),
    .pop_data  (head_s),
    .full      (full_s),
    .empty     (empty_s),
    .level     (fifo_level)
  );

  // Free-running timestamp and overflow drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_r       <= 32'd0;
      drop_count <= 32'd0;
    end else begin
      ts_r <= ts_r + 32'd1;
      if (push_s && full_s && !pop_s) drop_count <= drop_count + 32'd1;
    end
  end

  // Message sequencer: beat registers advance only on a handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      m_axis_tdata  <= 64'd0;
      m_axis_tkeep  <= 8'h00;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      token_r       <= 32'd0;
      tx_count      <= 32'd0;
      qty_lo_r      <= 16'd0;
      price_r       <= 32'd0;
      conf_r        <= 16'd0;
      stamp_r       <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pop_s) begin
            state_r       <= ST_BEAT0;
            m_axis_tdata  <= ouch_beat0(head_s.side, token_r, head_s.quantity);
            m_axis_tkeep  <= 8'hFF;
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= 1'b0;
            token_r       <= token_r + 32'd1;
            qty_lo_r      <= head_s.quantity[15:0];
            price_r       <= head_s.price;
            conf_r        <= head_s.confidence;
            stamp_r       <= head_s.timestamp;
          end
        end
        ST_BEAT0: begin
          if (handshake_s) begin
            state_r      <= ST_BEAT1;
            m_axis_tdata <= ouch_beat1(qty_lo_r, price_r, conf_r);
          end
        end
        ST_BEAT1: begin
          if (handshake_s) begin
            state_r      <= ST_BEAT2;
            m_axis_tdata <= ouch_beat2(stamp_r);
            m_axis_tkeep <= 8'h0F;
            m_axis_tlast <= 1'b1;
          end
        end
        ST_BEAT2: begin
          if (handshake_s) begin
            tx_count <= tx_count + 32'd1;
            if (pop_s) begin
              state_r       <= ST_BEAT0;
              m_axis_tdata  <= ouch_beat0(head_s.side, token_r, head_s.quantity);
              m_axis_tkeep  <= 8'hFF;
              m_axis_tlast  <= 1'b0;
              token_r       <= token_r + 32'd1;
              qty_lo_r      <= head_s.quantity[15:0];
              price_r       <= head_s.price;
              conf_r        <= head_s.confidence;
              stamp_r       <= head_s.timestamp;
            end else begin
              state_r       <= ST_IDLE;
              m_axis_tdata  <= 64'd0;
              m_axis_tkeep  <= 8'h00;
              m_axis_tvalid <= 1'b0;
              m_axis_tlast  <= 1'b0;
            end
          end
        end
        default: begin
          state_r       <= ST_IDLE;
          m_axis_tvalid <= 1'b0;
          m_axis_tlast  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trade_ouch_tx.sv
// Directed bench for trade_ouch_tx: latency, filtering, stall stability,
// overflow, simultaneous push/pop while full and mid-packet reset.
module tb_trade_ouch_tx;
  import trade_ouch_tx_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n;
  trade_signal_t trade_in;
  logic [63:0]   m_axis_tdata;
  logic [7:0]    m_axis_tkeep;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic          m_axis_tready;
  logic [31:0]   tx_count;
  logic [31:0]   drop_count;
  logic [4:0]    fifo_level;

  int errors = 0;
  int checks = 0;
  int cyc;

  trade_ouch_tx #(
    .FIFO_DEPTH    (16),
    .MIN_CONFIDENCE(16'h0100)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .trade_in      (trade_in),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .tx_count      (tx_count),
    .drop_count    (drop_count),
    .fifo_level    (fifo_level)
  );

  always #5 clk = ~clk;

  // Edges since reset release; equals the timestamp a push at the next edge receives.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] swap32(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  function automatic trade_signal_t sig(input logic [1:0] act, input logic [15:0] conf,
                                        input logic [31:0] price, input logic [31:0] qty);
    trade_signal_t s;
    s.valid      = 1'b1;
    s.action     = act;
    s.confidence = conf;
    s.price      = price;
    s.quantity   = qty;
    return s;
  endfunction

  logic [31:0]   ts_exp;
  logic [31:0]   ts_sell;
  logic [63:0]   exp_data [3];
  logic [7:0]    exp_keep [3];
  logic [15:0]   pattern;
  trade_signal_t rejects [4];
  int            idx;
  logic          hs;
  logic          seen;
  int            m;
  int            b;
  logic [31:0]   tok;
  logic [7:0]    side;
  logic [7:0]    qlo;
  logic [7:0]    conf_hi;
  logic [31:0]   ts_m;

  initial begin
    trade_in      = '0;
    m_axis_tready = 1'b1;
    rst_n         = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_tdata", m_axis_tdata, 64'd0);
    check("rst_tkeep", 64'(m_axis_tkeep), 64'd0);
    check("rst_tlast", 64'(m_axis_tlast), 64'd0);
    check("rst_tx_count", 64'(tx_count), 64'd0);
    check("rst_drop_count", 64'(drop_count), 64'd0);
    check("rst_level", 64'(fifo_level), 64'd0);

    // Single Buy straight out of reset, pushed at the first edge (timestamp 0).
    ts_exp   = 32'(cyc);
    rst_n    = 1'b1;
    trade_in = sig(ACTION_BUY, 16'h7FFF, 32'h0012D687, 32'd100);
    @(negedge clk);
    trade_in = '0;
    check("t1_lat_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("t1_level", 64'(fifo_level), 64'd1);
    @(negedge clk);
    check("t1_b0_tvalid", 64'(m_axis_tvalid), 64'd1);
    check("t1_b0_tdata", m_axis_tdata, 64'h000000000000424F);
    check("t1_b0_tkeep", 64'(m_axis_tkeep), 64'hFF);
    check("t1_b0_tlast", 64'(m_axis_tlast), 64'd0);
    @(negedge clk);
    check("t1_b1_tdata", m_axis_tdata, 64'hFF7F87D612006400);
    check("t1_b1_tkeep", 64'(m_axis_tkeep), 64'hFF);
    @(negedge clk);
    check("t1_b2_tdata", m_axis_tdata, {32'h0, swap32(ts_exp)});
    check("t1_b2_tkeep", 64'(m_axis_tkeep), 64'h0F);
    check("t1_b2_tlast", 64'(m_axis_tlast), 64'd1);
    @(negedge clk);
    check("t1_idle_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("t1_tx_count", 64'(tx_count), 64'd1);

    // Hold, reserved and under-confidence signals are discarded silently.
    rejects[0] = sig(ACTION_HOLD, 16'hFFFF, 32'h1, 32'h1);
    rejects[1] = sig(2'b11, 16'hFFFF, 32'h1, 32'h1);
    rejects[2] = sig(ACTION_SELL, 16'h0010, 32'h1, 32'h1);
    rejects[3] = sig(ACTION_SELL, 16'h00FF, 32'h1, 32'h1);
    for (int i = 0; i < 4; i++) begin
      trade_in = rejects[i];
      @(negedge clk);
      check("t2_level", 64'(fifo_level), 64'd0);
    end
    trade_in = '0;
    repeat (2) @(negedge clk);
    check("t2_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("t2_drop_count", 64'(drop_count), 64'd0);

    // Sell at exactly the confidence floor, sent under a stalling tready pattern.
    ts_exp      = 32'(cyc);
    trade_in    = sig(ACTION_SELL, 16'h0100, 32'hDEADBEEF, 32'h01020304);
    exp_data[0] = 64'h020101000000534F;
    exp_data[1] = 64'h0001EFBEADDE0403;
    exp_data[2] = {32'h0, swap32(ts_exp)};
    exp_keep[0] = 8'hFF;
    exp_keep[1] = 8'hFF;
    exp_keep[2] = 8'h0F;
    pattern     = 16'h0129;
    idx  = 0;
    hs   = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40 && idx < 3; k++) begin
      @(negedge clk);
      trade_in = '0;
      if (hs) idx++;
      if (idx < 3) begin
        if (seen) check("t4_tvalid_held", 64'(m_axis_tvalid), 64'd1);
        if (m_axis_tvalid) begin
          seen = 1'b1;
          check("t4_tdata", m_axis_tdata, exp_data[idx]);
          check("t4_tkeep", 64'(m_axis_tkeep), 64'(exp_keep[idx]));
          check("t4_tlast", 64'(m_axis_tlast), 64'(idx == 2));
        end
        m_axis_tready = (k < 16) ? pattern[k] : 1'b1;
        hs = m_axis_tvalid && m_axis_tready;
      end
    end
    check("t4_all_beats", 64'(idx), 64'd3);
    check("t4_end_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("t4_tx_count", 64'(tx_count), 64'd2);
    m_axis_tready = 1'b1;

    // Reset while beat1 is on the bus.
    trade_in = sig(ACTION_BUY, 16'hFFFF, 32'h00000001, 32'h00000002);
    @(negedge clk);
    trade_in = '0;
    @(negedge clk);
    @(negedge clk);
    check("t6_b1_tdata", m_axis_tdata, 64'hFFFF010000000200);
    rst_n = 1'b0;
    #1;
    check("t6_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("t6_tdata", m_axis_tdata, 64'd0);
    check("t6_tx_count", 64'(tx_count), 64'd0);
    check("t6_level", 64'(fifo_level), 64'd0);
    @(negedge clk);

    // Twenty Buys with the MAC stalled: one in flight, sixteen queued, three dropped.
    rst_n         = 1'b1;
    m_axis_tready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      trade_in = sig(ACTION_BUY, 16'h2000, 32'h00100000, 32'(k));
      @(negedge clk);
    end
    trade_in = '0;
    check("t3_level_full", 64'(fifo_level), 64'd16);
    check("t3_drop_count", 64'(drop_count), 64'd3);
    check("t3_stall_tvalid", 64'(m_axis_tvalid), 64'd1);
    check("t3_stall_b0", m_axis_tdata, 64'h000000000000424F);

    // Drain back-to-back; a Sell lands on the edge that pops the full FIFO.
    m_axis_tready = 1'b1;
    ts_sell = 32'd0;
    for (int j = 0; j < 55; j++) begin
      if (j < 54) begin
        check("t3_b2b_tvalid", 64'(m_axis_tvalid), 64'd1);
        m = j / 3;
        b = j % 3;
        if (m < 17) begin
          tok = 32'(m); side = 8'h42; qlo = 8'(m); conf_hi = 8'h20; ts_m = 32'(m);
        end else begin
          tok = 32'd17; side = 8'h53; qlo = 8'h55; conf_hi = 8'h01; ts_m = ts_sell;
        end
        if (b == 0) begin
          check("t3_b0_hdr", 64'(m_axis_tdata[47:0]), 64'({swap32(tok), side, 8'h4F}));
        end else if (b == 1) begin
          check("t3_b1_qty", 64'(m_axis_tdata[15:0]), 64'({qlo, 8'h00}));
          check("t3_b1_conf", 64'(m_axis_tdata[63:48]), 64'({8'h00, conf_hi}));
        end else begin
          check("t3_b2_tdata", m_axis_tdata, {32'h0, swap32(ts_m)});
          check("t3_b2_tlast", 64'(m_axis_tlast), 64'd1);
        end
      end else begin
        check("t3_done_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("t3_tx_count", 64'(tx_count), 64'd18);
        check("t3_done_level", 64'(fifo_level), 64'd0);
      end
      if (j == 3) begin
        check("t5_level_kept", 64'(fifo_level), 64'd16);
        check("t5_drop_same", 64'(drop_count), 64'd3);
      end
      if (j == 2) begin
        trade_in = sig(ACTION_SELL, 16'h0100, 32'h00000001, 32'h00000055);
        ts_sell  = 32'(cyc);
      end else begin
        trade_in = '0;
      end
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/trade_ouch_tx.md
Name: trade_ouch_tx

Overview:
- Downstream of the MoE decision stage: consumes one-cycle trade_signal_t pulses and buffers them in a FIFO.
- Filters out Hold and low-confidence signals.
- Serialises each surviving signal into a 20-byte order-entry message on a 64-bit AXI-Stream master toward the 10GbE MAC TX path.
- The input has no backpressure, so the FIFO absorbs MAC stalls and overflow is dropped and counted.

Parameters:
FIFO_DEPTH, 16, entries in the message FIFO (power of 2, ≥2)
MIN_CONFIDENCE, 16'h0000, signals with confidence below this are discarded

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
trade_in  in  trade_signal_t  {valid, action[1:0], confidence[15:0], price[31:0], quantity[31:0]}; valid is a one-cycle pulse
m_axis_tdata  out  64  message beat; byte lane 0 = tdata[7:0] = first byte on wire
m_axis_tkeep  out  8  byte enables
m_axis_tvalid  out  1  beat valid
m_axis_tlast  out  1  last beat of message
m_axis_tready  in  1  MAC ready
tx_count  out  32  messages fully sent (tlast handshakes), wraps
drop_count  out  32  signals lost to FIFO overflow, wraps
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async, active-low):
  - All outputs are 0; FIFO is empty; FSM is IDLE.
  - Token counter and timestamp counter are 0.
  - Reset mid-packet abandons the message immediately: tvalid drops in the same cycle and no completion beat is sent.
- Action encoding: 00 Hold, 01 Buy, 10 Sell, 11 reserved.
- Push rule: a signal is pushed when valid=1, action is 01 or 10, and confidence ≥ MIN_CONFIDENCE. Everything else is silently discarded and not counted.
- Timestamp: a free-running 32-bit cycle counter; its value at the push edge is stored with the entry.
- Overflow: a push while full, with no pop in that cycle, is discarded and drop_count increments.
- Simultaneous push and pop while full: the push is accepted and the level is unchanged.
- FSM states: IDLE, BEAT0, BEAT1, BEAT2.
  - IDLE with FIFO non-empty: pop the entry, assign token = token counter, post-increment the counter (wraps FFFF_FFFF→0), register beat0, go to BEAT0.
  - BEATn advances only on the tvalid && tready handshake.
  - BEAT2 handshake with FIFO non-empty: pop and register the next beat0 with no idle cycle. Otherwise go to IDLE.
- AXI rules: tdata/tkeep/tlast stay stable while tvalid && !tready. tvalid never deasserts without a handshake, except on reset.
- Latency: trade_in.valid sampled at edge E0 (push); with the FSM idle, beat0 is valid after E1 (2-cycle latency).
- Full-rate throughput: 3 cycles per message.
- Message layout, 20 bytes, multi-byte fields big-endian:
  - Byte 0: 0x4F 'O'
  - Byte 1: side, 0x42 'B' or 0x53 'S'
  - Bytes 2-5: token
  - Bytes 6-9: quantity
  - Bytes 10-13: price
  - Bytes 14-15: confidence
  - Bytes 16-19: timestamp
- Beat keep/last:
  - Beat0 and beat1: tkeep=FF.
  - Beat2: tkeep=0F, tdata[63:32]=0, tlast=1.
- tx_count increments on the beat2 handshake.
- fifo_level reflects occupancy after each edge.

Decomposition:
- axi_stream_pkg additions:
  - ACTION_HOLD/BUY/SELL constants
  - OUCH_TYPE_ENTER=8'h4F, SIDE_BUY=8'h42, SIDE_SELL=8'h53
  - OUCH_MSG_BYTES=20
  - ouch_entry_t struct {side, quantity, price, confidence, timestamp}
- Sub-module sync_fifo, parameterised by width and depth:
  - ports push/pop/full/empty/level
  - registered storage; pop returns head data combinationally
- The FSM and beat formatting stay in trade_ouch_tx.

Test Plan:
1. Buy, price 0x0012D687, qty 100, conf 0x7FFF, tready=1, after reset → beat0 0x000000000000424F tkeep FF; beat1 0xFF7F87D612006400; beat2 tkeep 0F, tlast=1, tdata[31:0] = timestamp 0x00000000 byte-swapped (push at first edge). tx_count=1; beat0 valid 2 cycles after the pulse.
2. Pulses Hold, reserved(11), Sell conf 0x0010 with MIN_CONFIDENCE=0x0100 → no tvalid, drop_count=0, fifo_level=0.
3. tready=0, 20 consecutive Buy pulses, FIFO_DEPTH=16 → 1 entry in the FSM, fifo_level=16, drop_count=3; release tready → 17 messages with tokens 0..16 in order, back-to-back (51 consecutive tvalid cycles).
4. Random tready toggling during a message → tdata/tkeep/tlast held stable while stalled, no beat duplicated or skipped.
5. Sell pushed in the same cycle as a full-FIFO pop → accepted, level stays 16, drop_count unchanged, byte1=0x53.
6. rst_n asserted during beat1 → tvalid=0 immediately; counters, level and token reset to 0; first message after reset carries token 0.
